bcd2bin_seq: RTL and testbench



---
 rtl/bcd2bin_seq_pkg.sv | 18 +
 rtl/bcd2bin_seq_if.sv | 40 ++++
 rtl/bcd2bin_seq_bcd_digit_adj.sv | 10 +
 rtl/bcd2bin_seq.sv | 119 +++++++++++
 tb/tb_bcd2bin_seq.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the BCD <-> binary conversion paths: FSM encoding,
// default geometry and a digit validity helper.
package bcd2bin_seq_pkg;

  localparam int DIGITS_DEF = 3;
  localparam int BIN_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Request/result bundle between a BCD source (master) and the converter (slave).
// start is a request qualified by ready: a job is accepted on a rising edge where
// start=1 and ready=1; done pulses once with bin_out/err valid in that cycle.
interface bcd2bin_seq_if #(
  parameter int DIGITS = bcd2bin_seq_pkg::DIGITS_DEF,
  parameter int BIN_W  = bcd2bin_seq_pkg::BIN_W_DEF
) ();

  logic                          start;
  logic [4*DIGITS-1:0]           bcd_in;
  logic                          ready;
  logic                          busy;
  logic                          done;
  logic [BIN_W-1:0]              bin_out;
  logic                          err;
  bcd2bin_seq_pkg::state_t       state;

  modport master (
    output start,
    output bcd_in,
    input  ready,
    input  busy,
    input  done,
    input  bin_out,
    input  err,
    input  state
  );

  modport slave (
    input  start,
    input  bcd_in,
    output ready,
    output busy,
    output done,
    output bin_out,
    output err,
    output state
  );

endinterface

// File: rtl/bcd2bin_seq_bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: a digit that reads 8 or more
// after the right shift had a 10s carry pushed into it, so take 3 back off.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one shift per clock,
// BIN_W shifts per job; out-of-range digits short-circuit straight to an error result.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  bcd2bin_seq_if.slave bus
);

  localparam int              DIG_W    = 4 * DIGITS;
  localparam int              CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t              state_q;
  logic [DIG_W-1:0]    dig_q;
  logic [BIN_W-1:0]    bin_q;
  logic [CNT_W-1:0]    count_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [BIN_W-1:0]    bin_out_q;

  logic [DIG_W+BIN_W-1:0] shifted;
  logic [DIG_W-1:0]       dig_adj;
  logic                   in_valid;

  // The LSB of digit 0 falls into the MSB of the binary register.
  always_comb begin
    shifted = {1'b0, dig_q, bin_q[BIN_W-1:1]};
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shifted[BIN_W + 4*g +: 4]),
      .dout (dig_adj[4*g +: 4])
    );
  end

  always_comb begin
    in_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(bus.bcd_in[4*i +: 4])) in_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dig_q     <= '0;
      bin_q     <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            dig_q   <= bus.bcd_in;
            bin_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (in_valid) begin
              state_q <= ST_SHIFT;
              count_q <= '0;
            end else begin
              state_q   <= ST_DONE;
              bin_out_q <= '0;
              err_q     <= 1'b1;
              done_q    <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          dig_q   <= dig_adj;
          bin_q   <= shifted[BIN_W-1:0];
          count_q <= count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_q   <= ST_DONE;
            bin_out_q <= shifted[BIN_W-1:0];
            err_q     <= 1'b0;
            done_q    <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_out_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: directed and random conversions against a decimal
// arithmetic reference, plus handshake, back-to-back and abort scenarios.
module tb_bcd2bin_seq;
  import bcd2bin_seq_pkg::*;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int LAT_OK = BIN_W + 1;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [10:0] model(input logic [11:0] v);
    int acc;
    int d;
    acc = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) return {1'b1, 10'd0};
      acc += d * (10 ** i);
    end
    return {1'b0, 10'(acc)};
  endfunction

  function automatic int model_lat(input logic [11:0] v);
    logic [10:0] r;
    r = model(v);
    return r[10] ? 1 : LAT_OK;
  endfunction

  function automatic logic [11:0] rand_valid();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.ready && w < 40) begin
      @(negedge clk);
      w++;
    end
  endtask

  // lat = 1 means done seen in the cycle right after the accepting edge.
  task automatic do_conv(input logic [11:0] v, output int lat,
                         output logic [10:0] res, output logic busy_ok);
    wait_ready();
    bus.bcd_in = v;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 12'($urandom);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy || bus.ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!bus.busy || bus.ready) busy_ok = 1'b0;
    res = bus.done ? {bus.err, bus.bin_out} : 11'h7FF;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.bcd_in = 12'h123;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.ready, bus.busy, bus.done, bus.err, bus.bin_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 10'd0}) begin
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b err=%b bin=%0d, want 1 0 0 0 0",
               bus.ready, bus.busy, bus.done, bus.err, bus.bin_out);
    end else n_pass++;
    n_total++;
    if (bus.state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE);
    else n_pass++;
    bus.start = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_directed();
    logic [11:0] vals [4];
    logic [10:0] res;
    logic [10:0] held;
    int          lat;
    logic        bok;
    vals[0] = 12'h999; vals[1] = 12'h000; vals[2] = 12'h512; vals[3] = 12'h001;
    for (int i = 0; i < 4; i++) begin
      do_conv(vals[i], lat, res, bok);
      n_total++;
      if (res !== model(vals[i])) $display("FAIL directed_result %h: got %h want %h", vals[i], res, model(vals[i]));
      else n_pass++;
      n_total++;
      if (lat !== LAT_OK) $display("FAIL directed_latency %h: got %0d want %0d", vals[i], lat, LAT_OK);
      else n_pass++;
      n_total++;
      if (bok !== 1'b1) $display("FAIL directed_busy %h: got %b want 1", vals[i], bok);
      else n_pass++;
      held = {bus.err, bus.bin_out};
      @(negedge clk);
      n_total++;
      if ({bus.done, bus.err, bus.bin_out} !== {1'b0, held}) begin
        $display("FAIL directed_hold %h: got done=%b res=%h want done=0 res=%h", vals[i], bus.done, {bus.err, bus.bin_out}, held);
      end else n_pass++;
    end
  endtask

  task automatic test_invalid();
    logic [10:0] res;
    int          lat;
    logic        bok;
    do_conv(12'h0A5, lat, res, bok);
    n_total++;
    if (res !== {1'b1, 10'd0}) $display("FAIL invalid_result: got %h want %h", res, {1'b1, 10'd0});
    else n_pass++;
    n_total++;
    if (lat !== 1) $display("FAIL invalid_latency: got %0d want 1", lat);
    else n_pass++;
    do_conv(12'h042, lat, res, bok);
    n_total++;
    if (res !== {1'b0, 10'd42}) $display("FAIL after_invalid_result: got %h want %h", res, {1'b0, 10'd42});
    else n_pass++;
    n_total++;
    if (lat !== LAT_OK) $display("FAIL after_invalid_latency: got %0d want %0d", lat, LAT_OK);
    else n_pass++;
  endtask

  task automatic test_ignore_busy_start();
    int          dones;
    logic [10:0] res;
    wait_ready();
    bus.bcd_in = 12'h456;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.bcd_in = 12'h123;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    res   = 11'h7FF;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin
        dones++;
        res = {bus.err, bus.bin_out};
      end
      @(negedge clk);
    end
    n_total++;
    if (dones !== 1) $display("FAIL ignore_done_count: got %0d want 1", dones);
    else n_pass++;
    n_total++;
    if (res !== model(12'h456)) $display("FAIL ignore_result: got %h want %h", res, model(12'h456));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;
    logic [11:0] v;
    int          ndone;
    int          last;
    int          cyc;
    ndone = 0;
    last  = -1;
    cyc   = 0;
    wait_ready();
    v = rand_valid();
    bus.bcd_in = v;
    exp_q.push_back(model(v));
    bus.start = 1'b1;
    while (ndone < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        n_total++;
        if ({bus.err, bus.bin_out} !== exp_v) $display("FAIL b2b_result: got %h want %h", {bus.err, bus.bin_out}, exp_v);
        else n_pass++;
        if (last >= 0) begin
          n_total++;
          if (cyc - last !== BIN_W + 2) $display("FAIL b2b_period: got %0d want %0d", cyc - last, BIN_W + 2);
          else n_pass++;
        end
        last = cyc;
        ndone++;
        if (ndone < 4) begin
          v = rand_valid();
          bus.bcd_in = v;
          exp_q.push_back(model(v));
        end else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    n_total++;
    if (ndone !== 4) $display("FAIL b2b_done_count: got %0d want 4", ndone);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int          dones;
    logic [10:0] res;
    int          lat;
    logic        bok;
    wait_ready();
    bus.bcd_in = 12'h777;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.ready, bus.busy, bus.done, bus.err, bus.bin_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 10'd0}) begin
      $display("FAIL abort_outputs: got rdy=%b busy=%b done=%b err=%b bin=%0d, want 1 0 0 0 0",
               bus.ready, bus.busy, bus.done, bus.err, bus.bin_out);
    end else n_pass++;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    n_total++;
    if (dones !== 0) $display("FAIL abort_no_done: got %0d want 0", dones);
    else n_pass++;
    do_conv(12'h250, lat, res, bok);
    n_total++;
    if (res !== {1'b0, 10'd250}) $display("FAIL after_abort_result: got %h want %h", res, {1'b0, 10'd250});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] v;
    logic [10:0] res;
    int          lat;
    logic        bok;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
        else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      do_conv(v, lat, res, bok);
      n_total++;
      if (res !== model(v)) $display("FAIL random_result %h: got %h want %h", v, res, model(v));
      else n_pass++;
      n_total++;
      if (lat !== model_lat(v)) $display("FAIL random_latency %h: got %0d want %0d", v, lat, model_lat(v));
      else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    test_reset();
    test_directed();
    test_invalid();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
